// File: rtl/smachine_input_conditioner.sv
// S-Machine input conditioner: syncs and debounces two switches and the run button.
// Define SMACHINE_RUN_TOGGLE_EN to make the run button toggle enable instead of hold-to-run.
`timescale 1ns/1ps
module smachine_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic switch0_raw,
    input  logic switch1_raw,
    input  logic run_raw,
    output logic switch0,
    output logic switch1,
    output logic switch0_rise,
    output logic switch1_rise,
    output logic enable
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // channel index: 0 = switch0, 1 = switch1, 2 = run
    logic [2:0]       raw;
    logic [2:0]       s1;
    logic [2:0]       s2;
    logic [2:0]       stable;
    logic [2:0]       done;
    logic [CNT_W-1:0] cnt [3];

    assign raw = {run_raw, switch1_raw, switch0_raw};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    always_comb begin
        done = '0;
        for (int i = 0; i < 3; i++) begin
            done[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
    end

    // any return to the stable level drops the partial count
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (done[i]) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else if (s2[i] != stable[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            switch0_rise <= 1'b0;
            switch1_rise <= 1'b0;
        end else begin
            switch0_rise <= done[0] & s2[0];
            switch1_rise <= done[1] & s2[1];
        end
    end

    assign switch0 = stable[0];
    assign switch1 = stable[1];

`ifdef SMACHINE_RUN_TOGGLE_EN
    logic run_toggle;

    always_ff @(posedge clk) begin
        if (reset) begin
            run_toggle <= 1'b0;
        end else if (done[2] & s2[2]) begin
            run_toggle <= ~run_toggle;
        end
    end

    assign enable = run_toggle;
`else
    assign enable = stable[2];
`endif

endmodule

// File: tb/tb_smachine_input_conditioner.sv
// Scoreboard bench for smachine_input_conditioner with DEBOUNCE_CYCLES=4.
// Expected output vectors are queued per edge and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_smachine_input_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic switch0_raw = 1'b0;
    logic switch1_raw = 1'b0;
    logic run_raw = 1'b0;
    logic switch0;
    logic switch1;
    logic switch0_rise;
    logic switch1_rise;
    logic enable;

    int checks = 0;
    int errors = 0;

    string      nq[$];
    logic [4:0] eq[$];
    string      mon_name;
    logic [4:0] mon_want;
    logic [4:0] mon_got;

    always #5 clk = ~clk;

    smachine_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .switch0_raw (switch0_raw),
        .switch1_raw (switch1_raw),
        .run_raw     (run_raw),
        .switch0     (switch0),
        .switch1     (switch1),
        .switch0_rise(switch0_rise),
        .switch1_rise(switch1_rise),
        .enable      (enable)
    );

    // vector order: {enable, switch1_rise, switch0_rise, switch1, switch0}
    function automatic logic [4:0] ex(logic en, logic r1, logic r0,
                                      logic v1, logic v0);
        return {en, r1, r0, v1, v0};
    endfunction

    task automatic step(input string nm, input logic rst,
                        input logic [2:0] raw, input logic [4:0] exp);
        reset = rst;
        {run_raw, switch1_raw, switch0_raw} = raw;
        @(posedge clk);
        #1;
        nq.push_back(nm);
        eq.push_back(exp);
    endtask

    task automatic clear();
        repeat (2) step("clear", 1'b1, 3'b000, 5'b00000);
    endtask

    always @(negedge clk) begin
        if (eq.size() > 0) begin
            mon_name = nq.pop_front();
            mon_want = eq.pop_front();
            mon_got  = {enable, switch1_rise, switch0_rise, switch1, switch0};
            checks++;
            if (mon_got !== mon_want) begin
                errors++;
                $display("FAIL %s t=%0t: got %b want %b (en,r1,r0,s1,s0)",
                         mon_name, $time, mon_got, mon_want);
            end
        end
    end

    initial begin
        logic [5:0] bpat;
        logic       b;
        logic       rr;
        logic       en;

        // reset hold with every raw input high
        repeat (3) step("reset_hold", 1'b1, 3'b111, 5'b00000);
        for (int j = 1; j <= 8; j++) begin
            step("reset_release", 1'b0, 3'b111,
                 ex(j >= 6, j == 6, j == 6, j >= 6, j >= 6));
        end

        // clean step on switch0, then release (no pulse on fall)
        clear();
        for (int k = 0; k < 10; k++) begin
            step("clean_rise", 1'b0, 3'b001,
                 ex(1'b0, 1'b0, k == 5, 1'b0, k >= 5));
        end
        for (int k = 0; k < 8; k++) begin
            step("clean_fall", 1'b0, 3'b000,
                 ex(1'b0, 1'b0, 1'b0, 1'b0, k < 5));
        end

        // bounce on switch1: 1,1,0,1,1,0 then held 1
        clear();
        bpat = 6'b011011;
        for (int i = 0; i < 16; i++) begin
            b = (i < 6) ? bpat[i] : 1'b1;
            step("bounce", 1'b0, {1'b0, b, 1'b0},
                 ex(1'b0, i == 11, 1'b0, i >= 11, 1'b0));
        end

        // run: press 10, release 10, press 10, release 10
        clear();
        for (int i = 0; i < 40; i++) begin
            rr = (i < 10) || (i >= 20 && i < 30);
`ifdef SMACHINE_RUN_TOGGLE_EN
            en = (i >= 5) && (i < 25);
`else
            en = ((i >= 5) && (i < 15)) || ((i >= 25) && (i < 35));
`endif
            step("run", 1'b0, {rr, 1'b0, 1'b0}, ex(en, 1'b0, 1'b0, 1'b0, 1'b0));
        end

        // reset mid-count restarts the debounce
        clear();
        for (int i = 0; i < 3; i++) begin
            step("midreset_pre", 1'b0, 3'b001, 5'b00000);
        end
        step("midreset_rst", 1'b1, 3'b001, 5'b00000);
        for (int j = 1; j <= 8; j++) begin
            step("midreset_post", 1'b0, 3'b001,
                 ex(1'b0, 1'b0, j == 6, 1'b0, j >= 6));
        end

        // all three channels step together
        clear();
        for (int i = 0; i < 10; i++) begin
            step("simul", 1'b0, 3'b111,
                 ex(i >= 5, i == 5, i == 5, i >= 5, i >= 5));
        end

        @(negedge clk);
        #1;
        checks++;
        if (eq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", eq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
